// File: rtl/eth_ingress_arbiter.sv
// Frame-atomic round-robin arbiter that merges NUM_PORTS AXI-Stream sources
// onto the single ingress port of the ethernet frame parser.
//
// state | meaning
// IDLE  | no frame in flight; pick the next requester circularly from rr_ptr
// BUSY  | granted source passed straight through until its tlast handshake
module eth_ingress_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  input  logic [NUM_PORTS-1:0]            port_enable,
  output logic                            busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  frame_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q;
  logic [ID_WIDTH-1:0]  pick;
  logic                 pick_vld;
  logic [NUM_PORTS-1:0] req;
  logic                 frame_end;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];

  assign req = s_axis_tvalid & port_enable;

  // First requester at or after rr_ptr, wrapping around the port range.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_vld && req[(int'(rr_ptr_q) + k) % NUM_PORTS]) begin
        pick     = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_PORTS);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (frame_end) begin
        rr_ptr_q <= (grant_q == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        if (frame_end) state_d = IDLE;
      end
    endcase
  end

  // Zero-latency pass-through of the granted source; nothing is buffered.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = grant_q;
    s_axis_tready = '0;
    busy          = 1'b0;
    if (state_q == BUSY) begin
      m_axis_tdata           = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
      busy                   = 1'b1;
    end
  end

  assign frame_end = busy & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (frame_end && (cnt_q[grant_q] != '1)) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign frame_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: doc/eth_ingress_arbiter.md
Name: eth_ingress_arbiter

Overview:
- Shares one ethernet_frame_parser ingress port between NUM_PORTS AXI-Stream sources.
- Arbitration is frame-atomic and round-robin. A granted source keeps the parser until its tlast beat handshakes.
- Provides a per-port enable mask for configuration, the source index alongside each beat, and per-port frame counters for status.
- Sits directly upstream of the parser's s_axis interface.

Parameters:
- NUM_PORTS, 4: number of requesting sources; legal range 2..8.
- DATA_WIDTH, 64: AXI-Stream data width, matching the parser.
- CNT_WIDTH, 16: width of each per-port frame counter.
- ID_WIDTH, $clog2(NUM_PORTS): width of the grant index.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed per-source data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-source valid.
- s_axis_tlast  in  NUM_PORTS  per-source end of frame.
- s_axis_tready  out  NUM_PORTS  per-source ready.
- m_axis_tdata  out  DATA_WIDTH  data to the parser.
- m_axis_tvalid  out  1  valid to the parser.
- m_axis_tlast  out  1  last to the parser.
- m_axis_tready  in  1  ready from the parser.
- m_axis_tid  out  ID_WIDTH  index of the source driving the current beat.
- port_enable  in  NUM_PORTS  per-port arbitration enable (configuration).
- busy  out  1  high while a frame is in flight (state BUSY).
- frame_count  out  NUM_PORTS*CNT_WIDTH  per-port count of completed frames.

Behaviour:
- Reset (rst_n=0 sampled at a posedge):
  - state=IDLE, grant=0, rr_ptr=0, all frame_count=0.
  - Outputs are combinational from state: while in IDLE, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0 and busy=0; m_axis_tdata and m_axis_tid are don't-care.
- Request vector: req[i] = s_axis_tvalid[i] & port_enable[i].
- State IDLE:
  - No beat is passed and all s_axis_tready=0.
  - If req is nonzero, grant is registered as the first set req bit searching circularly from rr_ptr upward (rr_ptr, rr_ptr+1, … wrapping modulo NUM_PORTS). Next state is BUSY.
  - If req is zero, stay in IDLE.
- State BUSY (combinational mux on the registered grant g):
  - m_axis_tdata = s_axis_tdata[g], m_axis_tvalid = s_axis_tvalid[g], m_axis_tlast = s_axis_tlast[g], m_axis_tid = g.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready bits are 0. This is a combinational pass-through with no buffering and zero added beat latency.
  - busy=1.
- Frame end: on m_axis_tvalid & m_axis_tready & m_axis_tlast:
  - next state is IDLE;
  - rr_ptr = (g+1) mod NUM_PORTS;
  - frame_count[g] increments, saturating at all-ones.
- Timing:
  - Exactly one IDLE bubble cycle between consecutive frames.
  - From req asserted with the arbiter in IDLE, the first beat can transfer on the next cycle.
- Lock rules:
  - In BUSY, changes to port_enable and req on other ports are ignored.
  - Deasserting port_enable[g] mid-frame does not abort the frame.
  - s_axis_tvalid[g] dropping mid-frame inserts bubbles (m_axis_tvalid=0) but keeps the grant.
- Simultaneous requests: strict round-robin order. With all ports requesting continuously, grants cycle 0,1,2,3,0,…
- rr_ptr wraps from NUM_PORTS-1 to 0.
- A single-beat frame (tvalid and tlast on the first beat) completes in one BUSY cycle.
- Reset mid-frame: the arbiter returns to IDLE immediately. Any residual beats of the interrupted frame are later arbitrated as a new frame; sources are reset together with the arbiter.
- m_axis_tdata/tlast/tid must be stable while m_axis_tvalid=1 and m_axis_tready=0. This holds by construction because the source is AXI-compliant and the grant is held.

Test Plan:
- Single source: port 0 sends the 5 beats 1122334455667788, 99aabbccddeeff00, 0800450000000000, deadbeefdeadbeef, cafebabecafebabe (tlast on the 5th) → all 5 appear on m_axis in order with m_axis_tid=0, tlast only on the 5th beat; frame_count[0]=1; busy falls on the cycle after tlast.
- Round-robin: ports 0–3 each hold a 2-beat frame pending from the same cycle → frames are granted in order 0,1,2,3 with one idle cycle between frames; m_axis_tid follows that order; each frame_count=1.
- Atomicity and backpressure: port 1 sends a 4-beat frame while port 2 requests; m_axis_tready is toggled 1,0,0,1,… → no port-2 beat is interleaved; port-1 data is held stable during stalls; port 2 is granted only after port 1's tlast handshake.
- Enable mask: port_enable=4'b1011 with all ports requesting → port 2 is never granted and s_axis_tready[2] stays 0; port_enable[0] is cleared mid-frame on port 0 → that frame still completes.
- Wrap and saturation: with CNT_WIDTH=4, send 17 single-beat frames on port 3 → frame_count[3] sticks at 4'hF; rr_ptr wraps to 0 after each port-3 grant.
- Reset mid-frame: assert rst_n=0 after beat 2 of a 5-beat frame → on the next cycle busy=0, m_axis_tvalid=0, all counters=0; after reset is released, the next request is granted from port 0 first.
